// File: rtl/msdf_operand_serializer.sv
// Takes a pair of two's-complement fractional operands, converts each to
// sign/magnitude and streams them MSD-first as radix-2 signed digits, then zero pad.
module msdf_operand_serializer #(
    parameter logic [7:0] RADIX_MODE    = 8'd1,
    parameter string      ENCODING_MODE = "signed-digit",
    parameter int         DATA_BITS     = 16,
    parameter int         PAD_DIGITS    = 3,
    parameter logic [7:0] DATA_WIDTH    = 8'd2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_s_valid,
    input  logic [DATA_BITS-1:0]       i_s_data_x,
    input  logic [DATA_BITS-1:0]       i_s_data_y,
    output logic                       o_s_ready,
    output logic                       o_mbus_wen,
    output logic [DATA_WIDTH-1:0]      o_mbus_wdata_x,
    output logic [DATA_WIDTH-1:0]      o_mbus_wdata_y,
    output logic                       o_mbus_wvalid,
    output logic                       o_mbus_wlast,
    input  logic                       i_mbus_wready,
    output logic                       o_sat,
    output logic                       o_busy
);
    localparam int NDIG  = DATA_BITS - 1;
    localparam int TOTAL = NDIG + PAD_DIGITS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int DW    = int'(DATA_WIDTH);
    localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
    localparam logic [CW-1:0] TOTAL_M1C = CW'(TOTAL - 1);
    localparam bit BORROW_SAVE = (ENCODING_MODE == "borrow-save");

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_STREAM} state_t;

    function automatic logic [1:0] f_encode(input logic s, input logic b);
        if (!b)
            return 2'b00;
        else if (BORROW_SAVE)
            return s ? 2'b11 : 2'b01;
        else
            return s ? 2'b01 : 2'b10;
    endfunction

    state_t            r_state, w_state_next;
    logic [CW-1:0]     r_beat, w_beat_next;
    logic              r_sign_x, r_sign_y, w_sign_x_next, w_sign_y_next;
    logic [NDIG-1:0]   r_mag_x, r_mag_y, w_mag_x_next, w_mag_y_next;
    logic              r_s_ready, w_s_ready_next;
    logic              r_wen, w_wen_next;
    logic              r_wlast, w_wlast_next;
    logic [1:0]        r_dig_x, r_dig_y, w_dig_x_next, w_dig_y_next;
    logic              r_sat, w_sat_next;
    logic              r_busy, w_busy_next;

    // -1 has no positive fractional counterpart, so it clamps to the largest magnitude
    logic [DATA_BITS-1:0] w_neg_x, w_neg_y;
    logic                 w_sat_x, w_sat_y;
    logic [NDIG-1:0]      w_in_mag_x, w_in_mag_y;

    assign w_neg_x    = -i_s_data_x;
    assign w_neg_y    = -i_s_data_y;
    assign w_sat_x    = (i_s_data_x == {1'b1, {NDIG{1'b0}}});
    assign w_sat_y    = (i_s_data_y == {1'b1, {NDIG{1'b0}}});
    assign w_in_mag_x = w_sat_x ? {NDIG{1'b1}} :
                        (i_s_data_x[DATA_BITS-1] ? w_neg_x[NDIG-1:0] : i_s_data_x[NDIG-1:0]);
    assign w_in_mag_y = w_sat_y ? {NDIG{1'b1}} :
                        (i_s_data_y[DATA_BITS-1] ? w_neg_y[NDIG-1:0] : i_s_data_y[NDIG-1:0]);

    always_comb begin
        w_state_next   = r_state;
        w_beat_next    = r_beat;
        w_sign_x_next  = r_sign_x;
        w_sign_y_next  = r_sign_y;
        w_mag_x_next   = r_mag_x;
        w_mag_y_next   = r_mag_y;
        w_s_ready_next = 1'b0;
        w_wen_next     = 1'b0;
        w_wlast_next   = 1'b0;
        w_dig_x_next   = 2'b00;
        w_dig_y_next   = 2'b00;
        w_sat_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_ready_next = 1'b1;
                if (r_s_ready && i_s_valid) begin
                    w_state_next   = ST_ARM;
                    w_s_ready_next = 1'b0;
                    w_sign_x_next  = i_s_data_x[DATA_BITS-1];
                    w_sign_y_next  = i_s_data_y[DATA_BITS-1];
                    w_mag_x_next   = w_in_mag_x;
                    w_mag_y_next   = w_in_mag_y;
                    w_sat_next     = w_sat_x | w_sat_y;
                end
            end
            ST_ARM: begin
                if (i_mbus_wready) begin
                    w_state_next = ST_STREAM;
                    w_beat_next  = CW'(1);
                    w_wen_next   = 1'b1;
                    w_wlast_next = (TOTAL == 1);
                    w_dig_x_next = f_encode(r_sign_x, r_mag_x[NDIG-1]);
                    w_dig_y_next = f_encode(r_sign_y, r_mag_y[NDIG-1]);
                    w_mag_x_next = r_mag_x << 1;
                    w_mag_y_next = r_mag_y << 1;
                end
            end
            ST_STREAM: begin
                if (r_beat == TOTAL_C) begin
                    w_state_next   = ST_IDLE;
                    w_s_ready_next = 1'b1;
                end else begin
                    // Magnitudes shift in zeros, so pad beats fall out as zero digits
                    w_beat_next  = r_beat + CW'(1);
                    w_wen_next   = 1'b1;
                    w_wlast_next = (r_beat == TOTAL_M1C);
                    w_dig_x_next = f_encode(r_sign_x, r_mag_x[NDIG-1]);
                    w_dig_y_next = f_encode(r_sign_y, r_mag_y[NDIG-1]);
                    w_mag_x_next = r_mag_x << 1;
                    w_mag_y_next = r_mag_y << 1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_beat    <= '0;
            r_sign_x  <= 1'b0;
            r_sign_y  <= 1'b0;
            r_mag_x   <= '0;
            r_mag_y   <= '0;
            r_s_ready <= 1'b0;
            r_wen     <= 1'b0;
            r_wlast   <= 1'b0;
            r_dig_x   <= 2'b00;
            r_dig_y   <= 2'b00;
            r_sat     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_beat    <= w_beat_next;
            r_sign_x  <= w_sign_x_next;
            r_sign_y  <= w_sign_y_next;
            r_mag_x   <= w_mag_x_next;
            r_mag_y   <= w_mag_y_next;
            r_s_ready <= w_s_ready_next;
            r_wen     <= w_wen_next;
            r_wlast   <= w_wlast_next;
            r_dig_x   <= w_dig_x_next;
            r_dig_y   <= w_dig_y_next;
            r_sat     <= w_sat_next;
            r_busy    <= w_busy_next;
        end
    end

    generate
        if (RADIX_MODE == 8'd1) begin : g_radix2
            assign o_s_ready      = r_s_ready;
            assign o_mbus_wen     = r_wen;
            assign o_mbus_wvalid  = r_wen;
            assign o_mbus_wlast   = r_wlast;
            assign o_mbus_wdata_x = DW'(r_dig_x);
            assign o_mbus_wdata_y = DW'(r_dig_y);
            assign o_sat          = r_sat;
            assign o_busy         = r_busy;
        end else begin : g_unsupported
            assign o_s_ready      = 1'b0;
            assign o_mbus_wen     = 1'b0;
            assign o_mbus_wvalid  = 1'b0;
            assign o_mbus_wlast   = 1'b0;
            assign o_mbus_wdata_x = '0;
            assign o_mbus_wdata_y = '0;
            assign o_sat          = 1'b0;
            assign o_busy         = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_msdf_operand_serializer.sv
// Directed bench for msdf_operand_serializer: a signed-digit and a borrow-save
// instance share stimulus; outputs are sampled on the falling edge.
module tb_msdf_operand_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [15:0] s_data_x, s_data_y;
    logic        wready;
    logic        s_ready, wen, wvalid, wlast, sat, busy;
    logic [1:0]  wdata_x, wdata_y;
    logic        bs_s_ready, bs_wen, bs_wvalid, bs_wlast, bs_sat, bs_busy;
    logic [1:0]  bs_wdata_x, bs_wdata_y;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    msdf_operand_serializer dut (
        .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid),
        .i_s_data_x(s_data_x), .i_s_data_y(s_data_y), .o_s_ready(s_ready),
        .o_mbus_wen(wen), .o_mbus_wdata_x(wdata_x), .o_mbus_wdata_y(wdata_y),
        .o_mbus_wvalid(wvalid), .o_mbus_wlast(wlast), .i_mbus_wready(wready),
        .o_sat(sat), .o_busy(busy)
    );

    msdf_operand_serializer #(.ENCODING_MODE("borrow-save")) dut_bs (
        .i_clk(clk), .i_rst(rst), .i_s_valid(s_valid),
        .i_s_data_x(s_data_x), .i_s_data_y(s_data_y), .o_s_ready(bs_s_ready),
        .o_mbus_wen(bs_wen), .o_mbus_wdata_x(bs_wdata_x), .o_mbus_wdata_y(bs_wdata_y),
        .o_mbus_wvalid(bs_wvalid), .o_mbus_wlast(bs_wlast), .i_mbus_wready(wready),
        .o_sat(bs_sat), .o_busy(bs_busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1; s_valid = 1'b0; s_data_x = '0; s_data_y = '0; wready = 1'b0;
        tick(); tick();
        got = {s_ready, wen, wvalid, wlast, wdata_x, wdata_y, sat, busy};
        n_checks++;
        if (got !== 10'b0) $display("FAIL reset_outputs: got %b want %b", got, 10'b0);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({s_ready, busy} !== 2'b10) $display("FAIL reset_release_ready: got %b want 10", {s_ready, busy});
        else n_pass++;
        $display("reset: ready=%b", s_ready);
    endtask

    task automatic test_basic();
        logic [6:0] got, exp;
        s_valid = 1'b1; s_data_x = 16'h4000; s_data_y = 16'hE000; wready = 1'b1;
        tick();
        s_valid = 1'b0;
        n_checks++;
        if ({s_ready, busy, wvalid, sat} !== 4'b0100) $display("FAIL basic_arm: got %b want 0100", {s_ready, busy, wvalid, sat});
        else n_pass++;
        tick();
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k == 1) ? 2'b10 : 2'b00, (k == 2) ? 2'b01 : 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL basic_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({s_ready, busy, wen, wlast} !== 4'b1000) $display("FAIL basic_done: got %b want 1000", {s_ready, busy, wen, wlast});
        else n_pass++;
        $display("basic: X=4000 Y=E000 streamed 18 beats");
    endtask

    task automatic test_saturation();
        logic [6:0] got, exp;
        s_valid = 1'b1; s_data_x = 16'h8000; s_data_y = 16'h0001; wready = 1'b1;
        tick();
        s_valid = 1'b0;
        n_checks++;
        if (sat !== 1'b1) $display("FAIL sat_pulse: got %b want 1", sat);
        else n_pass++;
        tick();
        n_checks++;
        if (sat !== 1'b0) $display("FAIL sat_single: got %b want 0", sat);
        else n_pass++;
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k <= 15) ? 2'b01 : 2'b00, (k == 15) ? 2'b10 : 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL sat_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            tick();
        end
        // both operands at -1 still give one pulse
        s_valid = 1'b1; s_data_x = 16'h8000; s_data_y = 16'h8000;
        tick();
        s_valid = 1'b0;
        n_checks++;
        if (sat !== 1'b1) $display("FAIL sat_both_pulse: got %b want 1", sat);
        else n_pass++;
        tick();
        n_checks++;
        if (sat !== 1'b0) $display("FAIL sat_both_single: got %b want 0", sat);
        else n_pass++;
        for (int k = 1; k <= 19; k++) tick();
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL sat_both_done: got %b want 1", s_ready);
        else n_pass++;
        $display("saturation: X=8000 clamped, sat pulsed");
    endtask

    task automatic test_start_gating();
        logic [6:0] got, exp;
        s_valid = 1'b1; s_data_x = 16'h7FFF; s_data_y = 16'h0000; wready = 1'b0;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({wvalid, busy} !== 2'b01) $display("FAIL gate_hold%0d: got %b want 01", i, {wvalid, busy});
            else n_pass++;
            tick();
        end
        wready = 1'b1;
        tick();
        wready = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k <= 15) ? 2'b10 : 2'b00, 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL gate_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({s_ready, wen} !== 2'b10) $display("FAIL gate_done: got %b want 10", {s_ready, wen});
        else n_pass++;
        $display("start_gating: held 5 cycles, no stall after start");
    endtask

    task automatic test_borrow_save();
        logic [6:0] got, exp, got_sd, exp_sd;
        s_valid = 1'b1; s_data_x = 16'hC000; s_data_y = 16'h2000; wready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        for (int k = 1; k <= 18; k++) begin
            exp    = {1'b1, 1'b1, (k == 18), (k == 1) ? 2'b11 : 2'b00, (k == 2) ? 2'b01 : 2'b00};
            got    = {bs_wen, bs_wvalid, bs_wlast, bs_wdata_x, bs_wdata_y};
            exp_sd = {1'b1, 1'b1, (k == 18), (k == 1) ? 2'b01 : 2'b00, (k == 2) ? 2'b10 : 2'b00};
            got_sd = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL bs_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            n_checks++;
            if (got_sd !== exp_sd) $display("FAIL sd_neg_beat%0d: got %b want %b", k, got_sd, exp_sd);
            else n_pass++;
            tick();
        end
        $display("borrow_save: X=C000 Y=2000 streamed");
    endtask

    task automatic test_reset_mid();
        logic [6:0] got, exp;
        logic [9:0] all;
        s_valid = 1'b1; s_data_x = 16'h4000; s_data_y = 16'hE000; wready = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        for (int k = 1; k < 7; k++) tick();
        n_checks++;
        if ({wvalid, wlast} !== 2'b10) $display("FAIL rstmid_beat7: got %b want 10", {wvalid, wlast});
        else n_pass++;
        rst = 1'b1;
        tick();
        all = {s_ready, wen, wvalid, wlast, wdata_x, wdata_y, sat, busy};
        n_checks++;
        if (all !== 10'b0) $display("FAIL rstmid_cleared: got %b want %b", all, 10'b0);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if ({s_ready, busy, wen, wlast} !== 4'b1000) $display("FAIL rstmid_ready: got %b want 1000", {s_ready, busy, wen, wlast});
        else n_pass++;
        s_valid = 1'b1; s_data_x = 16'h2000; s_data_y = 16'hFFFF;
        tick();
        s_valid = 1'b0;
        tick();
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k == 2) ? 2'b10 : 2'b00, (k == 15) ? 2'b01 : 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL rstmid_fresh_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            tick();
        end
        $display("reset_mid: burst aborted, fresh X=2000 Y=FFFF streamed");
    endtask

    task automatic test_back_to_back();
        logic [6:0] got, exp;
        s_valid = 1'b1; s_data_x = 16'h6000; s_data_y = 16'hA000; wready = 1'b1;
        tick();
        s_data_x = 16'h1000; s_data_y = 16'hF000;
        tick();
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k <= 2) ? 2'b10 : 2'b00, (k <= 2) ? 2'b01 : 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL b2b_a_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            if (k == 1) wready = 1'b0;
            tick();
        end
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", s_ready);
        else n_pass++;
        tick();
        s_valid = 1'b0;
        n_checks++;
        if ({s_ready, busy, wvalid} !== 3'b010) $display("FAIL b2b_arm: got %b want 010", {s_ready, busy, wvalid});
        else n_pass++;
        tick();
        n_checks++;
        if (wvalid !== 1'b0) $display("FAIL b2b_wait: got %b want 0", wvalid);
        else n_pass++;
        wready = 1'b1;
        tick();
        for (int k = 1; k <= 18; k++) begin
            exp = {1'b1, 1'b1, (k == 18), (k == 3) ? 2'b10 : 2'b00, (k == 3) ? 2'b01 : 2'b00};
            got = {wen, wvalid, wlast, wdata_x, wdata_y};
            n_checks++;
            if (got !== exp) $display("FAIL b2b_b_beat%0d: got %b want %b", k, got, exp);
            else n_pass++;
            tick();
        end
        $display("back_to_back: second pair started when wready returned");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_start_gating();
        test_borrow_save();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
